// File: rtl/nn_seq_pkg.sv
// Shared types and defaults for the nested-loop index sequencer.
// The state encoding here is the one the sequencer's FSM register uses.
package nn_seq_pkg;

    localparam int NN_IDX_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } nn_seq_state_e;

endpackage

// File: rtl/nn_wrap_counter.sv
// Index counter that returns to zero after reaching a programmable inclusive limit.
// Termination is by comparison with max, so an all-ones limit never relies on overflow.
module nn_wrap_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] max,
    output logic [W-1:0] cnt,
    output logic         at_max
);

    assign at_max = (cnt == max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= at_max ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/nn_loop_sequencer.sv
// Two-level (outer = neuron, inner = input/weight) index generator for one FC layer.
// Emits one (outer, inner) pair per valid/ready beat, then pulses done for one cycle.
module nn_loop_sequencer
    import nn_seq_pkg::*;
#(
    parameter int INNER_W = NN_IDX_W_DEFAULT,
    parameter int OUTER_W = NN_IDX_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [INNER_W-1:0] inner_max,
    input  logic [OUTER_W-1:0] outer_max,
    output logic               idx_valid,
    input  logic               idx_ready,
    output logic [INNER_W-1:0] inner_idx,
    output logic [OUTER_W-1:0] outer_idx,
    output logic               first_inner,
    output logic               last_inner,
    output logic               busy,
    output logic               done
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_DONE = ST_DONE;

    // Handshake: a beat transfers on a rising edge where idx_valid && idx_ready;
    // while idx_valid is high and idx_ready low, indices and flags hold.
    // state is a plain register so external checkers can observe the FSM directly.
    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [INNER_W-1:0] inner_lim;
    logic [OUTER_W-1:0] outer_lim;
    logic               inner_at_max;
    logic               outer_at_max;
    logic               beat;
    logic               start_acc;
    logic               cnt_clr;

    assign beat      = idx_valid & idx_ready;
    assign start_acc = (state == S_IDLE) & start & ~abort;
    assign cnt_clr   = abort | (state != S_RUN);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (beat && inner_at_max && outer_at_max) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        // abort outranks every transition, including start and the final beat
        if (abort) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Limits are frozen for the whole run; later changes on the inputs are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inner_lim <= '0;
            outer_lim <= '0;
        end else if (start_acc) begin
            inner_lim <= inner_max;
            outer_lim <= outer_max;
        end
    end

    nn_wrap_counter #(.W(INNER_W)) u_inner (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (cnt_clr),
        .en     (beat),
        .max    (inner_lim),
        .cnt    (inner_idx),
        .at_max (inner_at_max)
    );

    nn_wrap_counter #(.W(OUTER_W)) u_outer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (cnt_clr),
        .en     (beat & inner_at_max),
        .max    (outer_lim),
        .cnt    (outer_idx),
        .at_max (outer_at_max)
    );

    // All outputs decode registered state only; no input reaches them combinationally.
    assign idx_valid   = (state == S_RUN);
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);
    assign first_inner = idx_valid & (inner_idx == '0);
    assign last_inner  = idx_valid & inner_at_max;

endmodule
